// File: rtl/dmem_if.sv
// Load/store bus between the core's control unit and the data-memory responder.
interface dmem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM serving one load/store at a time with WAIT_CYCLES wait states.
// Define DMEM_MISALIGN_TRAP_EN to reject accesses with addr[1:0] != 0.
//
// state   | meaning
// IDLE    | waiting for mem_read/mem_write; request captured here
// WAIT    | wait-state countdown; access performed on the edge leaving it
// RESP    | done pulse (and err if the access was rejected)
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                  state, state_nx;
    logic [3:0]              cnt, cnt_nx;
    logic                    capture;
    logic                    do_access;

    logic                    rd_q, wr_q, bad_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic                    req;
    logic                    bad_now;
    logic [DEPTH_LOG2-1:0]   idx_now;

    logic                    acc_rd, acc_wr, acc_bad;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;

    logic [31:0]             mem [2**DEPTH_LOG2];

    logic                    unused_addr;
    assign unused_addr = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

    assign req     = bus.mem_read | bus.mem_write;
    assign idx_now = bus.addr[DEPTH_LOG2+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad_now = (bus.mem_read & bus.mem_write) | (bus.addr[1:0] != 2'b00);
`else
    assign bad_now = bus.mem_read & bus.mem_write;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        capture   = 1'b0;
        do_access = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_nx  = ST_RESP;
                    end else begin
                        cnt_nx   = CNT_INIT;
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nx  = ST_RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the access happens on the capture edge, so use live inputs.
    assign acc_rd    = capture ? bus.mem_read : rd_q;
    assign acc_wr    = capture ? bus.mem_write : wr_q;
    assign acc_bad   = capture ? bad_now : bad_q;
    assign acc_idx   = capture ? idx_now : idx_q;
    assign acc_wdata = capture ? bus.wdata : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (capture) begin
                rd_q    <= bus.mem_read;
                wr_q    <= bus.mem_write;
                bad_q   <= bad_now;
                idx_q   <= idx_now;
                wdata_q <= bus.wdata;
            end
            if (do_access) begin
                err_q <= acc_bad;
                if (acc_rd && !acc_wr && !acc_bad) begin
                    rdata_q <= mem[acc_idx];
                end
            end
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (do_access && acc_wr && !acc_rd && !acc_bad && !rst) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.done  = (state == ST_RESP);
    assign bus.err   = (state == ST_RESP) & err_q;
    assign bus.stall = ~rst & (((state == ST_IDLE) & req) | (state == ST_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with 2 wait states, one with 0 wait states.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if bus0 ();
    dmem_if bus1 ();

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        sel = 1'b0;
    logic        rd_s = 1'b0;
    logic        wr_s = 1'b0;
    logic [31:0] addr_s = 32'd0;
    logic [31:0] wdata_s = 32'd0;

    assign bus0.mem_read  = sel ? 1'b0 : rd_s;
    assign bus0.mem_write = sel ? 1'b0 : wr_s;
    assign bus0.addr      = addr_s;
    assign bus0.wdata     = wdata_s;
    assign bus1.mem_read  = sel ? rd_s : 1'b0;
    assign bus1.mem_write = sel ? wr_s : 1'b0;
    assign bus1.addr      = addr_s;
    assign bus1.wdata     = wdata_s;

    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    assign stall_o = sel ? bus1.stall : bus0.stall;
    assign done_o  = sel ? bus1.done  : bus0.done;
    assign err_o   = sel ? bus1.err   : bus0.err;
    assign rdata_o = sel ? bus1.rdata : bus0.rdata;

    int  checks = 0;
    int  failures = 0;
    time t_done = 0;

    // Issues one request in the next cycle; returns cycles to done (-1 on timeout),
    // number of stall-high cycles seen, and err/rdata in the done cycle.
    task automatic do_access(input logic s, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output int stl,
                             output logic e, output logic [31:0] q);
        @(negedge clk);
        sel = s; rd_s = rd; wr_s = wr; addr_s = a; wdata_s = d;
        #1;
        stl = (stall_o === 1'b1) ? 1 : 0;
        lat = -1; e = 1'bx; q = 32'hxxxxxxxx;
        @(posedge clk);
        #1;
        rd_s = 1'b0; wr_s = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (lat < 0) begin
                @(negedge clk);
                if (stall_o === 1'b1) stl++;
                if (done_o === 1'b1) begin
                    lat = k; e = err_o; q = rdata_o; t_done = $time;
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus0.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus0.stall); end
        checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
        checks++; if (bus0.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus0.err); end
        checks++; if (bus0.rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", bus0.rdata); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        int lat, stl; logic e; logic [31:0] q;
        do_access(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, lat, stl, e, q);
        checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
        checks++; if (stl !== 3) begin failures++; $display("FAIL store_stall_cycles got=%0d exp=3", stl); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", e); end
        checks++; if (q !== 32'd0) begin failures++; $display("FAIL store_keeps_rdata got=%h exp=00000000", q); end
        do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, stl, e, q);
        checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
        checks++; if (q !== 32'hCAFEF00D) begin failures++; $display("FAIL load_data got=%h exp=cafef00d", q); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", e); end
    endtask

    task automatic test_reset_mid_access();
        int lat, stl; logic e; logic [31:0] q; logic seen;
        do_access(1'b0, 1'b0, 1'b1, 32'h10, 32'h11111111, lat, stl, e, q);
        @(negedge clk);
        sel = 1'b0; wr_s = 1'b1; rd_s = 1'b0; addr_s = 32'h10; wdata_s = 32'hDEADBEEF;
        @(posedge clk); #1; wr_s = 1'b0;
        @(negedge clk);
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL midwait_stall got=%b exp=1", stall_o); end
        rst = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_o); end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_o !== 1'b0) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_o !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%b exp=0", seen); end
        do_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, stl, e, q);
        checks++; if (q !== 32'h11111111) begin failures++; $display("FAIL rst_dropped_store got=%h exp=11111111", q); end
    endtask

    task automatic test_wrap();
        int lat, stl; logic e; logic [31:0] q;
        do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h99999999, lat, stl, e, q);
        do_access(1'b0, 1'b0, 1'b1, 32'h1000, 32'h1, lat, stl, e, q);
        do_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, stl, e, q);
        checks++; if (q !== 32'h1) begin failures++; $display("FAIL wrap_data got=%h exp=00000001", q); end
    endtask

    task automatic test_conflict();
        int lat, stl; logic e; logic [31:0] q;
        do_access(1'b0, 1'b0, 1'b1, 32'h20, 32'hAAAA5555, lat, stl, e, q);
        do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, stl, e, q);
        do_access(1'b0, 1'b1, 1'b1, 32'h20, 32'h5, lat, stl, e, q);
        checks++; if (lat !== 3) begin failures++; $display("FAIL conflict_latency got=%0d exp=3", lat); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL conflict_err got=%b exp=1", e); end
        checks++; if (q !== 32'hCAFEF00D) begin failures++; $display("FAIL conflict_rdata_held got=%h exp=cafef00d", q); end
        @(negedge clk);
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_after_done got=%b exp=0", err_o); end
        do_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, stl, e, q);
        checks++; if (q !== 32'hAAAA5555) begin failures++; $display("FAIL conflict_no_write got=%h exp=aaaa5555", q); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL conflict_next_err got=%b exp=0", e); end
    endtask

    task automatic test_misalign();
        int lat, stl; logic e; logic [31:0] q;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_err = 1'b1; exp_word = 32'hCAFEF00D;
`else
        exp_err = 1'b0; exp_word = 32'h7;
`endif
        do_access(1'b0, 1'b0, 1'b1, 32'h42, 32'h7, lat, stl, e, q);
        checks++; if (lat !== 3) begin failures++; $display("FAIL misalign_latency got=%0d exp=3", lat); end
        checks++; if (e !== exp_err) begin failures++; $display("FAIL misalign_err got=%b exp=%b", e, exp_err); end
        do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, stl, e, q);
        checks++; if (q !== exp_word) begin failures++; $display("FAIL misalign_word got=%h exp=%h", q, exp_word); end
    endtask

    task automatic test_wait0();
        int lat, stl; logic e; logic [31:0] q;
        do_access(1'b1, 1'b0, 1'b1, 32'h8, 32'h12345678, lat, stl, e, q);
        checks++; if (lat !== 1) begin failures++; $display("FAIL w0_store_latency got=%0d exp=1", lat); end
        do_access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, lat, stl, e, q);
        checks++; if (lat !== 1) begin failures++; $display("FAIL w0_load_latency got=%0d exp=1", lat); end
        checks++; if (stl !== 1) begin failures++; $display("FAIL w0_stall_cycles got=%0d exp=1", stl); end
        checks++; if (q !== 32'h12345678) begin failures++; $display("FAIL w0_load_data got=%h exp=12345678", q); end
    endtask

    task automatic test_back_to_back();
        int lat, stl; logic e; logic [31:0] q; time t0;
        do_access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, lat, stl, e, q);
        t0 = t_done;
        do_access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, lat, stl, e, q);
        checks++; if (t_done - t0 !== 20) begin failures++; $display("FAIL w0_b2b_period got=%0t exp=20", t_done - t0); end
        do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, stl, e, q);
        t0 = t_done;
        do_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, stl, e, q);
        checks++; if (t_done - t0 !== 40) begin failures++; $display("FAIL w2_b2b_period got=%0t exp=40", t_done - t0); end
        checks++; if (q !== 32'hAAAA5555) begin failures++; $display("FAIL w2_b2b_data got=%h exp=aaaa5555", q); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_reset_mid_access();
        test_wrap();
        test_conflict();
        test_misalign();
        test_wait0();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the target of the `mem_read`/`mem_write` strobes that the main control unit raises for loads and stores. It holds a word-addressed RAM and serves one access at a time with a programmable wait-state count. While an access is outstanding it stalls the datapath, and it completes each access with a one-cycle `done` pulse.

## Interface

**Parameters**
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 2: wait states per access, legal range 0..15.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `mem_read` in 1: load request from the control unit.
- `mem_write` in 1: store request from the control unit.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `rdata` out 32: load data; valid in the `done` cycle, held until the next load completes.
- `stall` out 1: freezes PC and pipeline while an access is pending.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: access rejected; valid in the `done` cycle only.

## Operation

- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:** `req = mem_read | mem_write`. On `req`, the block latches `addr`, `wdata` and the request type, then moves to WAIT, or directly to RESP when `WAIT_CYCLES == 0`.
- **WAIT:** a 4-bit counter loads `WAIT_CYCLES-1` and decrements each cycle. At 0 the block performs the access and moves to RESP.
- **RESP:** `done=1` for one cycle, then the block returns to IDLE. A request present in that IDLE cycle starts a new access.
- **Access:**
  - Word index is `addr[DEPTH_LOG2+1:2]`. Higher address bits are ignored, so addresses wrap modulo the RAM size.
  - A store writes the full word.
  - A load registers `mem[index]` into `rdata`.
- **Conflict:** if `mem_read` and `mem_write` are both 1 at capture, nothing is written, `rdata` is unchanged, and `err=1` in RESP.
- **Stores:** `rdata` keeps its previous value.
- **`stall`** is combinational: `(IDLE & req) | WAIT`. It is 0 in RESP and forced to 0 while `rst=1`.
- **Input sampling:** the datapath holds its inputs stable while `stall=1`; only the values present at the IDLE capture edge are used.
- **X on strobes:** X on `mem_read`/`mem_write` (undecoded opcode) is outside the contract, and the bench must not drive it.

## Timing

- **Reset values:** state IDLE, `rdata=0`, `done=0`, `err=0`, `stall=0`, wait counter 0.
- **Reset contents:** RAM contents are not reset and are retained across reset.
- **Latency:** a request first seen in IDLE at cycle N produces `done` at cycle N+1+WAIT_CYCLES. `stall` is high for cycles N..N+WAIT_CYCLES. One access completes per 2+WAIT_CYCLES cycles under back-to-back requests.
- **Write commit:** the write happens on the edge entering RESP, so a load issued right after a store to the same word returns the new data.
- **Reset mid-access:**
  - The block returns to IDLE immediately and the pending access is dropped.
  - A store not yet committed has no effect.
  - `done` does not pulse.

## Configuration

- **`DMEM_MISALIGN_TRAP_EN` defined:**
  - An access with `addr[1:0] != 0` is rejected: no write, `rdata` unchanged, `err=1` in RESP.
  - Latency is unchanged.
- **`DMEM_MISALIGN_TRAP_EN` undefined:** `addr[1:0]` is ignored and the access proceeds on the aligned word. `err` is driven only by the read/write conflict.

## Test plan

- **Reset:** assert `rst` mid-WAIT of a store of 0xDEADBEEF to 0x10 → `stall=0`, `done=0` at once; a later load of 0x10 returns the pre-store value.
- **Store then load, WAIT_CYCLES=2:** store 0xCAFEF00D to 0x40 at cycle N → `stall` high N..N+2, `done` at N+3; load 0x40 issued the next request cycle → `rdata=0xCAFEF00D`, `err=0`.
- **WAIT_CYCLES=0:** load → `done` at N+1, `stall` high only at N; back-to-back loads complete every 2 cycles.
- **Wrap:** with DEPTH_LOG2=10, store 0x1 to 0x1000, then load 0x0 → `rdata=0x1`.
- **Conflict:** `mem_read=mem_write=1`, `addr=0x20`, `wdata=5` → `err=1` with `done`; a load of 0x20 afterwards returns the old contents.
- **Misalignment:**
  - With `DMEM_MISALIGN_TRAP_EN`: store 7 to 0x42 → `err=1` and the word at 0x40 is unchanged.
  - Without the macro: the same store gives `err=0`, and a load of 0x40 returns 7.
